// File: rtl/register_reader.sv
// register_reader: snapshots a WIDTH-bit register value on request and streams it out
// LSB-first as CHUNK-bit beats over a valid/ready handshake, then pulses done.
// Optional build macro: REGISTER_READER_PARITY_EN adds a registered even-parity bit per beat;
// without it beatParity is tied low and the port list is unchanged.
`timescale 1ns/1ps

module register_reader #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] snapIn,
  input  logic             start,
  output logic             busy,
  output logic [CHUNK-1:0] beatData,
  output logic             beatValid,
  input  logic             beatReady,
  output logic             beatLast,
  output logic             beatParity,
  output logic             done
);

  localparam int unsigned NBEATS = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [IdxW-1:0]   beat_idx_q, beat_idx_d;

  // Registered outputs; their next values are decoded from the next state so every output
  // is a plain flop with no combinational path from start or beatReady.
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [CHUNK-1:0]  data_q, data_d;

  // Next-state logic: capture on start, advance on each accepted beat, one DONE cycle.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    beat_idx_d = beat_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d   = snapIn;
          beat_idx_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        // beatValid is high throughout SEND, so beatReady alone marks a transfer.
        if (beatReady) begin
          if (beat_idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state; beat data is zero outside SEND.
  always_comb begin
    valid_d = (state_d == StSend);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    last_d  = valid_d && (beat_idx_d == LastIdx);
    data_d  = '0;
    for (int unsigned i = 0; i < NBEATS; i++) begin
      if (valid_d && (beat_idx_d == IdxW'(i))) begin
        data_d = shadow_d[i*CHUNK +: CHUNK];
      end
    end
  end

  // FSM state, snapshot and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      beat_idx_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      beat_idx_q <= beat_idx_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

`ifdef REGISTER_READER_PARITY_EN
  logic parity_q, parity_d;

  // Parity follows the beat register, so it holds on stalls and is 0 when data is 0.
  always_comb begin
    parity_d = ^data_d;
  end

  // Parity flop registered alongside the beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign beatParity = parity_q;
`else
  assign beatParity = 1'b0;
`endif

  assign busy      = busy_q;
  assign beatValid = valid_q;
  assign beatLast  = last_q;
  assign done      = done_q;
  assign beatData  = data_q;

endmodule

// File: tb/tb_register_reader.sv
// Testbench for register_reader: table of read vectors plus hand-written reset-abort and
// back-to-back sequences; expected beats are queued at start and popped on each transfer.
`timescale 1ns/1ps

module tb_register_reader;

  logic        clk;
  logic        reset;
  logic [63:0] snapIn;
  logic        start;
  logic        busy;
  logic [15:0] beatData;
  logic        beatValid;
  logic        beatReady;
  logic        beatLast;
  logic        beatParity;
  logic        done;

  register_reader #(
    .WIDTH(64),
    .CHUNK(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .snapIn    (snapIn),
    .start     (start),
    .busy      (busy),
    .beatData  (beatData),
    .beatValid (beatValid),
    .beatReady (beatReady),
    .beatLast  (beatLast),
    .beatParity(beatParity),
    .done      (done)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        parity;
  } beat_t;

  typedef struct {
    logic [63:0]      snap;
    logic [3:0][15:0] beats;      // [0] is the first beat
    int               stall_beat; // beat index to stall on, -1 for none
    int               stall_n;    // cycles of beatReady=0 on that beat
    bit               hot;        // re-assert start with new snapIn during SEND
    int               lat;        // edges from start sample to done
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[5];
  int    xfer_edge[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit done_seen = 0;
  bit prev_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_par(input logic [15:0] d);
`ifdef REGISTER_READER_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_beats(input logic [3:0][15:0] b);
    for (int i = 0; i < 4; i++) begin
      beat_t e;
      e.data   = b[i];
      e.last   = (i == 3);
      e.parity = exp_par(b[i]);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: sampled mid-cycle; a beat transfers at the next rising edge when valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (beatValid) begin
          check("busy_in_send", busy, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected no beat", beatData);
          end else begin
            check("beat_data", beatData, exp_q[0].data);
            check("beat_last", beatLast, exp_q[0].last);
            check("beat_parity", beatParity, exp_q[0].parity);
            if (beatReady) begin
              void'(exp_q.pop_front());
              xfer_cnt++;
              xfer_edge.push_back(cyc + 1);
            end
          end
        end else begin
          check("parity_idle", beatParity, 0);
        end
        if (done) begin
          check("done_single_cycle", prev_done, 0);
          check("done_busy", busy, 1);
          done_seen = 1;
          done_cyc  = cyc;
          done_cnt++;
        end
        prev_done = done;
      end else begin
        prev_done = 0;
      end
    end
  end

  task automatic idle_checks();
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_valid", beatValid, 0);
      check("idle_done", done, 0);
    end
  endtask

  task automatic do_read(input vec_t v);
    int s_cyc;
    int budget;
    int stalls_left;
    done_seen   = 0;
    xfer_cnt    = 0;
    stalls_left = v.stall_n;
    @(posedge clk); #1;
    snapIn    = v.snap;
    start     = 1'b1;
    beatReady = 1'b1;  // ready before valid must be ignored
    push_beats(v.beats);
    @(posedge clk); #1;
    s_cyc = cyc;
    start = 1'b0;
    budget = 60;
    while (!done_seen && budget > 0) begin
      beatReady = 1'b1;
      if (beatValid && xfer_cnt == v.stall_beat && stalls_left > 0) begin
        beatReady = 1'b0;
        stalls_left--;
      end
      if (v.hot && beatValid && xfer_cnt >= 1 && xfer_cnt <= 2) begin
        start  = 1'b1;
        snapIn = '1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      budget--;
    end
    start = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no done expected done after %0d edges", v.lat);
    end else begin
      check("done_latency", done_cyc - s_cyc, v.lat);
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    idle_checks();
  endtask

  initial begin
    int budget;
    int dc;
    reset     = 1'b1;
    start     = 1'b0;
    beatReady = 1'b0;
    snapIn    = '0;

    vecs[0] = '{snap: 64'h0123_4567_89AB_CDEF,
                beats: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF},
                stall_beat: -1, stall_n: 0, hot: 0, lat: 4};
    vecs[1] = '{snap: 64'h0123_4567_89AB_CDEF,
                beats: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF},
                stall_beat: 1, stall_n: 3, hot: 0, lat: 7};
    vecs[2] = '{snap: 64'h0123_4567_89AB_CDEF,
                beats: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF},
                stall_beat: -1, stall_n: 0, hot: 1, lat: 4};
    vecs[3] = '{snap: 64'h0000_0000_0000_0001,
                beats: {16'h0000, 16'h0000, 16'h0000, 16'h0001},
                stall_beat: -1, stall_n: 0, hot: 0, lat: 4};
    vecs[4] = '{snap: 64'hA5A5_0F0F_FFFF_8001,
                beats: {16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h8001},
                stall_beat: 3, stall_n: 1, hot: 0, lat: 5};

    // Reset state, asserted without a clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst0_busy", busy, 0);
    check("rst0_valid", beatValid, 0);
    check("rst0_done", done, 0);
    check("rst0_last", beatLast, 0);
    check("rst0_data", beatData, 0);
    check("rst0_parity", beatParity, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_read(vecs[i]);
    end

    // Asynchronous reset while beat 2 is on the port abandons the read.
    done_seen = 0;
    xfer_cnt  = 0;
    @(posedge clk); #1;
    snapIn    = vecs[0].snap;
    start     = 1'b1;
    beatReady = 1'b1;
    push_beats(vecs[0].beats);
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 20;
    while (xfer_cnt < 2 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (xfer_cnt < 2) begin
      checks++;
      errors++;
      $display("FAIL abort_setup: got %0d transfers expected 2", xfer_cnt);
    end
    dc = done_cnt;
    #1 reset = 1'b0;
    #1;
    check("abort_valid", beatValid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", beatData, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_idle_busy", busy, 0);
    end
    check("abort_no_done", done_cnt, dc);
    do_read(vecs[0]);

    // Back-to-back reads with start held high.
    xfer_cnt = 0;
    xfer_edge.delete();
    dc = done_cnt;
    @(posedge clk); #1;
    snapIn    = vecs[0].snap;
    start     = 1'b1;
    beatReady = 1'b1;
    push_beats(vecs[0].beats);
    push_beats(vecs[4].beats);
    @(posedge clk); #1;
    snapIn = vecs[4].snap;
    budget = 40;
    while (done_cnt - dc < 2 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    start = 1'b0;
    check("b2b_done_count", done_cnt - dc, 2);
    check("b2b_xfer_count", xfer_edge.size(), 8);
    if (xfer_edge.size() >= 5) begin
      check("b2b_gap", xfer_edge[4] - xfer_edge[3], 3);
    end
    check("b2b_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    idle_checks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
